// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared constants, FSM state type, write-request record and the
// framebuffer address helper for the 640x480 1-bpp pixel fetch block.
// Optional feature macro: FB_XOR_WRITE_EN (adds the xor_en field to wr_req_t).
// -----------------------------------------------------------------------------
package fb_pkg;

   localparam int H_ACTIVE      = 640;
   localparam int V_ACTIVE      = 480;
   localparam int WORDS_PER_ROW = 40;
   localparam int FB_DEPTH      = 19200;
   localparam int FB_ADDR_W     = 15;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WR_RD,
      WR_WB,
      CLR
   } fb_state_t;

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
      logic       data;
`ifdef FB_XOR_WRITE_EN
      logic       xor_en;
`endif
   } wr_req_t;

   // Word address of (row y, 16-pixel group): y*40 + group, built from shifts
   // so no multiplier is inferred.
   function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [8:0] y,
                                                    input logic [5:0] group);
      logic [FB_ADDR_W-1:0] y_w;
      y_w = {6'd0, y};
      return (y_w << 5) + (y_w << 3) + {9'd0, group};
   endfunction

endpackage

// File: rtl/fb_pixel_fetch_if.sv
// -----------------------------------------------------------------------------
// fb_pixel_fetch_if
// Single-pixel write handshake used by drawing engines.
//   wr_valid  : request valid (master)
//   wr_ready  : request accepted when wr_valid && wr_ready (slave)
//   wr_x/wr_y : target column / row
//   wr_data   : pixel value to write
//   wr_xor    : only with FB_XOR_WRITE_EN; new bit = old bit ^ wr_data
// -----------------------------------------------------------------------------
interface fb_pixel_fetch_if;

   logic       wr_valid;
   logic       wr_ready;
   logic [9:0] wr_x;
   logic [8:0] wr_y;
   logic       wr_data;
`ifdef FB_XOR_WRITE_EN
   logic       wr_xor;
`endif

   modport master (
      input  wr_ready,
      output wr_valid,
      output wr_x,
      output wr_y,
      output wr_data
`ifdef FB_XOR_WRITE_EN
      , output wr_xor
`endif
   );

   modport slave (
      output wr_ready,
      input  wr_valid,
      input  wr_x,
      input  wr_y,
      input  wr_data
`ifdef FB_XOR_WRITE_EN
      , input wr_xor
`endif
   );

endinterface

// File: rtl/fb_ram.sv
// -----------------------------------------------------------------------------
// fb_ram
// Single-port DEPTH x WIDTH word RAM with 1-cycle synchronous read, written
// so that synthesis maps it onto block RAM.
//   clk   : clock
//   we    : write enable
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : read data, valid the cycle after addr
// -----------------------------------------------------------------------------
module fb_ram
   import fb_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = FB_DEPTH,
   parameter int ADDR_W = FB_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset; a reset loop would stop block-RAM
   // inference, and the clear command zeroes the frame instead.
   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/fb_pixel_fetch.sv
// -----------------------------------------------------------------------------
// fb_pixel_fetch
// 1-bpp 640x480 framebuffer between the drawing engines and the VGA timing
// generator. Display words are double-buffered (cur_word/nxt_word): each
// 16-pixel group boundary swaps in the prefetched word and requests the next
// one. The display prefetch has priority over pixel writes (read-modify-write)
// and over the full-frame clear.
// Optional feature macro: FB_XOR_WRITE_EN (XOR write mode via wr.wr_xor).
//   CLOCK_50  : clock (pixel period = 2 cycles)
//   Reset     : synchronous, active-high
//   pixel_x/y : beam position from the timing generator
//   pixel     : LIT_VALUE or 0, one cycle after pixel_x/pixel_y
//   wr        : write handshake (slave)
//   clear_req : pulse, starts/restarts a full-frame clear
//   busy      : clear active or write RMW in progress
// -----------------------------------------------------------------------------
module fb_pixel_fetch
   import fb_pkg::*;
#(
   parameter int         WORD_W    = 16,
   parameter logic [9:0] LIT_VALUE = 10'h3FF
) (
   input  logic              CLOCK_50,
   input  logic              Reset,
   input  logic [9:0]        pixel_x,
   input  logic [8:0]        pixel_y,
   output logic [9:0]        pixel,
   fb_pixel_fetch_if.slave   wr,
   input  logic              clear_req,
   output logic              busy
);

   fb_state_t             state, state_nxt;
   logic [9:0]            x_q;
   logic [WORD_W-1:0]     cur_word, nxt_word;
   logic                  fetch_pending;
   logic [FB_ADDR_W-1:0]  fetch_addr, swap_addr, clr_cnt, req_addr;
   logic                  clr_active;
   wr_req_t               req;

   logic                  in_active, swap, wr_in_range, handshake, new_bit;
   logic [5:0]            group;
   logic [WORD_W-1:0]     sel_word, wb_word;

   logic                  ram_we;
   logic [FB_ADDR_W-1:0]  ram_addr;
   logic [WORD_W-1:0]     ram_wdata, ram_rdata;

   fb_ram #(.WIDTH(WORD_W), .DEPTH(FB_DEPTH), .ADDR_W(FB_ADDR_W)) u_ram (
      .clk   (CLOCK_50),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign group     = pixel_x[9:4];
   assign in_active = (pixel_x < 10'(H_ACTIVE)) && (pixel_y < 9'(V_ACTIVE));
   // A group boundary counts only on the first cycle of a new beam column.
   assign swap      = (pixel_x != x_q) && in_active && (pixel_x[3:0] == 4'd0);
   assign sel_word  = swap ? nxt_word : cur_word;

   assign wr_in_range = (wr.wr_x < 10'(H_ACTIVE)) && (wr.wr_y < 9'(V_ACTIVE));
   assign wr.wr_ready = (state == IDLE) && !fetch_pending && !clr_active;
   assign handshake   = wr.wr_valid && wr.wr_ready;
   assign req_addr    = fb_addr(req.y, req.x[9:4]);
   assign busy        = clr_active || (state == WR_RD) || (state == WR_WB);

   // Next display word: following group, or group 0 of the next row (479 -> 0).
   always_comb begin
      swap_addr = fb_addr(pixel_y, group + 6'd1);
      if (group == 6'(WORDS_PER_ROW - 1))
         swap_addr = fb_addr((pixel_y == 9'(V_ACTIVE - 1)) ? 9'd0 : pixel_y + 9'd1, 6'd0);
   end

   // Write-back word: old word with the target bit replaced (or toggled).
   always_comb begin
      new_bit = req.data;
`ifdef FB_XOR_WRITE_EN
      if (req.xor_en)
         new_bit = req.data ^ ram_rdata[req.x[3:0]];
`endif
      wb_word              = ram_rdata;
      wb_word[req.x[3:0]]  = new_bit;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      ram_we    = 1'b0;
      ram_addr  = fetch_addr;
      ram_wdata = '0;
      unique case (state)
         IDLE: begin
            // The read of fetch_addr issued here is captured in FETCH.
            if (fetch_pending)
               state_nxt = FETCH;
            else if (clr_active)
               state_nxt = CLR;
            else if (handshake && wr_in_range)
               state_nxt = WR_RD;
         end
         FETCH: state_nxt = IDLE;
         WR_RD: begin
            ram_addr  = req_addr;
            state_nxt = WR_WB;
         end
         WR_WB: begin
            ram_addr  = req_addr;
            ram_we    = 1'b1;
            ram_wdata = wb_word;
            state_nxt = IDLE;
         end
         CLR: begin
            // One word per visit, then back to IDLE so a fetch can cut in.
            ram_addr  = clr_cnt;
            ram_we    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments only, so every
   // reader in this clock edge sees the pre-edge values.
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state         <= IDLE;
         x_q           <= '0;
         cur_word      <= '0;
         nxt_word      <= '0;
         fetch_pending <= 1'b1;
         fetch_addr    <= '0;
         clr_active    <= 1'b0;
         clr_cnt       <= '0;
         req           <= '0;
         pixel         <= '0;
      end else begin
         state <= state_nxt;
         x_q   <= pixel_x;
         pixel <= (in_active && sel_word[pixel_x[3:0]]) ? LIT_VALUE : 10'd0;

         if (state == FETCH) begin
            nxt_word      <= ram_rdata;
            fetch_pending <= 1'b0;
         end
         // A new request outranks the completion of an older one.
         if (swap) begin
            cur_word      <= nxt_word;
            fetch_pending <= 1'b1;
            fetch_addr    <= swap_addr;
         end

         if (handshake) begin
            req.x    <= wr.wr_x;
            req.y    <= wr.wr_y;
            req.data <= wr.wr_data;
`ifdef FB_XOR_WRITE_EN
            req.xor_en <= wr.wr_xor;
`endif
         end

         if (state == CLR) begin
            if (clr_cnt == FB_ADDR_W'(FB_DEPTH - 1))
               clr_active <= 1'b0;
            else
               clr_cnt <= clr_cnt + 1'b1;
         end
         // A new clear request restarts the sweep from word 0.
         if (clear_req) begin
            clr_active <= 1'b1;
            clr_cnt    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_fb_pixel_fetch
// Directed bench for fb_pixel_fetch. The beam is driven directly so a chosen
// pixel can be displayed without sweeping a whole frame: the preceding group
// boundary is visited first (which prefetches the target word), then the
// target group boundary and column. Inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fb_pixel_fetch;

   logic       clk;
   logic       rst;
   logic [9:0] pixel_x;
   logic [8:0] pixel_y;
   logic [9:0] pixel;
   logic       clear_req;
   logic       busy;

   int checks = 0;
   int errors = 0;

   localparam logic [9:0] LIT = 10'h3FF;

   fb_pixel_fetch_if wr_if ();

   fb_pixel_fetch dut (
      .CLOCK_50  (clk),
      .Reset     (rst),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .pixel     (pixel),
      .wr        (wr_if),
      .clear_req (clear_req),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one write; the DUT is expected idle, so it must be accepted at
   // once, then busy must stay high for exp_busy cycles.
   task automatic do_write(input string tag, input int x, input int y, input logic d,
                           input int exp_busy);
      int n;
      wr_if.wr_x     = 10'(x);
      wr_if.wr_y     = 9'(y);
      wr_if.wr_data  = d;
      wr_if.wr_valid = 1'b1;
      n = 0;
      while (!wr_if.wr_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready_now"}, n, 0);
      @(negedge clk);
      wr_if.wr_valid = 1'b0;
      for (int k = 0; k < exp_busy; k++) begin
         check({tag, "_busy_rmw"}, busy, 1);
         @(negedge clk);
      end
      check({tag, "_busy_low"}, busy, 0);
   endtask

   // Display pixel (x,y) and compare it with exp.
   task automatic view(input string tag, input int x, input int y, input logic [9:0] exp);
      int g, px, py;
      g = x / 16;
      if (g > 0) begin
         px = (g - 1) * 16;
         py = y;
      end else begin
         px = 624;
         py = (y == 0) ? 479 : y - 1;
      end
      pixel_x = 10'd700;
      pixel_y = 9'(py);
      @(negedge clk);
      pixel_x = 10'(px);
      repeat (5) @(negedge clk);
      if (g == 0 && y == 0) begin
         // Cross vertical blanking: group boundaries there must not disturb
         // the row-0 group-0 word fetched at (624,479).
         pixel_y = 9'd490;
         for (int k = 0; k < 4; k++) begin
            pixel_x = 10'(k * 16);
            @(negedge clk);
            check({tag, "_vblank_dark"}, pixel, 0);
         end
      end
      pixel_y = 9'(y);
      pixel_x = 10'(g * 16);
      @(negedge clk);
      if (x != g * 16) begin
         pixel_x = 10'(x);
         @(negedge clk);
      end
      check(tag, pixel, exp);
      pixel_x = 10'd700;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int   n, idx, bx, by;
      logic hs;

      rst            = 1'b1;
      pixel_x        = 10'd700;
      pixel_y        = 9'd0;
      clear_req      = 1'b0;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_x     = '0;
      wr_if.wr_y     = '0;
      wr_if.wr_data  = 1'b0;
`ifdef FB_XOR_WRITE_EN
      wr_if.wr_xor   = 1'b0;
`endif

      // Reset state: fetch of word 0 is pending, so no write is accepted yet.
      repeat (2) @(negedge clk);
      check("rst_pixel", pixel, 0);
      check("rst_wr_ready", wr_if.wr_ready, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_wr_ready", wr_if.wr_ready, 1);

      // Reset 100 cycles into a clear aborts it.
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      repeat (100) @(negedge clk);
      check("midclear_busy", busy, 1);
      check("midclear_wr_ready", wr_if.wr_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_abort_busy", busy, 0);
      check("rst_abort_pixel", pixel, 0);
      repeat (3) @(negedge clk);

      // Full clear runs to completion.
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      check("clear_busy_start", busy, 1);
      n = 0;
      while (busy && n < 60000) begin
         @(negedge clk);
         n++;
      end
      check("clear_finished", busy, 0);
      check("clear_long_enough", (n >= 19199), 1);
      check("clear_wr_ready", wr_if.wr_ready, 1);
      view("clr_0_0", 0, 0, 0);
      view("clr_320_240", 320, 240, 0);
      view("clr_639_479", 639, 479, 0);

      // Single write.
      do_write("w17_3", 17, 3, 1'b1, 2);
      view("px_17_3", 17, 3, LIT);
      view("px_16_3", 16, 3, 0);
      view("px_18_3", 18, 3, 0);
      view("px_17_2", 17, 2, 0);

      // Frame corners and group edges.
      do_write("w0_0", 0, 0, 1'b1, 2);
      do_write("w639_479", 639, 479, 1'b1, 2);
      do_write("w15_0", 15, 0, 1'b1, 2);
      do_write("w16_0", 16, 0, 1'b1, 2);
      view("px_0_0_wrap", 0, 0, LIT);
      view("px_639_479", 639, 479, LIT);
      view("px_15_0", 15, 0, LIT);
      view("px_16_0", 16, 0, LIT);
      view("px_1_0", 1, 0, 0);
      view("px_14_0", 14, 0, 0);
      view("px_17_0", 17, 0, 0);
      view("px_0_1", 0, 1, 0);
      view("px_638_479", 638, 479, 0);

      // Out-of-range writes: accepted, no RMW, nothing lands in the frame.
      do_write("w700_10", 700, 10, 1'b1, 0);
      do_write("w5_480", 5, 480, 1'b1, 0);
      view("px_60_11_alias", 60, 11, 0);
      view("px_5_0", 5, 0, 0);
      view("px_5_479", 5, 479, 0);

      // Writing a zero erases a lit pixel.
      do_write("w17_3_erase", 17, 3, 1'b0, 2);
      view("px_17_3_erased", 17, 3, 0);

`ifdef FB_XOR_WRITE_EN
      wr_if.wr_xor = 1'b1;
      do_write("x8_8_a", 8, 8, 1'b1, 2);
      view("px_8_8_xor1", 8, 8, LIT);
      do_write("x8_8_b", 8, 8, 1'b1, 2);
      view("px_8_8_xor2", 8, 8, 0);
      wr_if.wr_xor = 1'b0;
`endif

      // Stress: diagonal (i,i) written back-to-back while the beam scans
      // active video, so fetches keep cutting into the write stream.
      bx  = 0;
      by  = 200;
      idx = 0;
      wr_if.wr_x     = 10'd0;
      wr_if.wr_y     = 9'd0;
      wr_if.wr_data  = 1'b1;
      wr_if.wr_valid = 1'b1;
      for (int cyc = 0; cyc < 4000 && idx < 480; cyc++) begin
         hs = wr_if.wr_valid && wr_if.wr_ready;
         if (cyc % 2 == 0) begin
            pixel_x = 10'(bx);
            pixel_y = 9'(by);
            bx++;
            if (bx == 800) begin
               bx = 0;
               by++;
            end
         end
         @(negedge clk);
         if (hs) begin
            idx++;
            wr_if.wr_x = 10'(idx);
            wr_if.wr_y = 9'(idx);
         end
      end
      wr_if.wr_valid = 1'b0;
      check("stress_all_accepted", idx, 480);
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("stress_drained", busy, 0);
      view("diag_37", 37, 37, LIT);
      view("diag_38_37", 38, 37, 0);
      view("diag_111", 111, 111, LIT);
      view("diag_250", 250, 250, LIT);
      view("diag_251_250", 251, 250, 0);
      view("diag_333", 333, 333, LIT);
      view("diag_479", 479, 479, LIT);
      view("diag_480_479", 480, 479, 0);
      view("diag_639_479_kept", 639, 479, LIT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
